// File: rtl/stream_buffer_ctrl_pkg.sv
// Shared definitions for the sample-stream buffer: FSM encodings and default sizing.
package stream_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } sbc_state_e;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEPTH_WIDTH = 10;
    localparam int DEF_HB_DIV      = 126000000;

endpackage

// File: rtl/stream_buffer_ctrl_fifo_core.sv
// Dual-pointer synchronous FIFO with registered read data, live level and flush.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sbc_fifo_core
    import stream_buffer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [DEPTH_WIDTH:0]  level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 2 ** DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_WIDTH:0]   wr_ptr_q;
    logic [DEPTH_WIDTH:0]   rd_ptr_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   wr_ok;
    logic                   rd_ok;

    // Flush overrides any same-cycle transfer; full/empty guard the pointers.
    assign wr_ok = wr_en_i && !full_o && !flush_i;
    assign rd_ok = rd_en_i && !empty_o && !flush_i;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[DEPTH_WIDTH] != rd_ptr_q[DEPTH_WIDTH]) &&
                       (wr_ptr_q[DEPTH_WIDTH-1:0] == rd_ptr_q[DEPTH_WIDTH-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = rd_data_q;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data_i;
        end
    end

    // Pointer and read-data registers; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: rtl/stream_buffer_ctrl.sv
// Sample-stream buffer between the FT245 RX port and the modulator FIFO-pull port.
// Holds the modulator off until START_LEVEL samples are buffered, re-primes after
// underruns, keeps overflow/underrun statistics and drives a heartbeat LED counter.
module stream_buffer_ctrl
    import stream_buffer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
    parameter int START_LEVEL = 512,
    parameter int REPRIME     = 1,
    parameter int CNT_WIDTH   = 16,
    parameter int HB_DIV      = DEF_HB_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_read,
    output logic                  m_empty,
    output logic [DEPTH_WIDTH:0]  level,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  overflow_cnt,
    output logic [CNT_WIDTH-1:0]  underrun_cnt,
    output logic [7:0]            leds
);

    localparam logic [DEPTH_WIDTH:0] START_LVL = (DEPTH_WIDTH+1)'(START_LEVEL);
    localparam int                   HB_W      = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    sbc_state_e             state_q, state_d;
    logic                   wr_en;
    logic                   rd_en;
    logic [DEPTH_WIDTH:0]   level_next;
    logic                   was_empty_q;
    logic                   underrun_evt;
    logic [CNT_WIDTH-1:0]   overflow_cnt_q;
    logic [CNT_WIDTH-1:0]   underrun_cnt_q;
    logic [HB_W-1:0]        hb_cnt_q;
    logic [7:0]             leds_q;

    assign s_ready = !full && !flush;
    assign wr_en   = s_valid && s_ready;
    assign rd_en   = m_read && !m_empty;

    sbc_fifo_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .wr_en_i   (wr_en),
        .wr_data_i (s_data),
        .rd_en_i   (rd_en),
        .rd_data_o (m_data),
        .level_o   (level),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Occupancy after this edge, so PREFILL can hand over on the filling write itself.
    assign level_next = flush ? '0
                      : level + (DEPTH_WIDTH+1)'(wr_en) - (DEPTH_WIDTH+1)'(rd_en);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: disable wins, then flush re-primes, then normal progression.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (flush) begin
            state_d = ST_PREFILL;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_PREFILL;
                ST_PREFILL: if (level_next >= START_LVL) state_d = ST_STREAM;
                ST_STREAM:  if (empty && (REPRIME != 0)) state_d = ST_PREFILL;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: the modulator only sees real emptiness while streaming.
    always_comb begin
        m_empty      = 1'b1;
        underrun_evt = 1'b0;
        if (state_q == ST_STREAM) begin
            m_empty      = empty;
            underrun_evt = empty && !was_empty_q;
        end
    end

    // Statistics counters, saturating; an underrun counts once per empty episode.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_cnt_q <= '0;
            underrun_cnt_q <= '0;
            was_empty_q    <= 1'b0;
        end else begin
            was_empty_q <= (state_q == ST_STREAM) && empty;
            if (s_valid && full && (overflow_cnt_q != '1)) begin
                overflow_cnt_q <= overflow_cnt_q + 1'b1;
            end
            if (underrun_evt && (underrun_cnt_q != '1)) begin
                underrun_cnt_q <= underrun_cnt_q + 1'b1;
            end
        end
    end

    // Heartbeat prescaler and LED counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q <= '0;
            leds_q   <= 8'hFF;
        end else if (hb_cnt_q == HB_W'(HB_DIV - 1)) begin
            hb_cnt_q <= '0;
            leds_q   <= leds_q + 8'd1;
        end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
        end
    end

    assign state        = state_q;
    assign overflow_cnt = overflow_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
    assign leds         = leds_q;

endmodule

// File: tb/tb_stream_buffer_ctrl.sv
// Directed self-checking bench for stream_buffer_ctrl with a 16-deep FIFO,
// START_LEVEL=4, REPRIME=1 and a heartbeat divider of 4.
module tb_stream_buffer_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        flush;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_read;
    logic        m_empty;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic [1:0]  state;
    logic [15:0] overflow_cnt;
    logic [15:0] underrun_cnt;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;

    stream_buffer_ctrl #(
        .DATA_WIDTH  (8),
        .DEPTH_WIDTH (4),
        .START_LEVEL (4),
        .REPRIME     (1),
        .CNT_WIDTH   (16),
        .HB_DIV      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_read       (m_read),
        .m_empty      (m_empty),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .state        (state),
        .overflow_cnt (overflow_cnt),
        .underrun_cnt (underrun_cnt),
        .leds         (leds)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic read,
                                 input logic en, input logic fl);
        s_valid = valid;
        s_data  = data;
        m_read  = read;
        enable  = en;
        flush   = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset values
        checkOutput("rst_m_data", 32'(m_data), 32'h00);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_m_empty", 32'(m_empty), 32'd1);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_ovf", 32'(overflow_cnt), 32'd0);
        checkOutput("rst_udr", 32'(underrun_cnt), 32'd0);
        checkOutput("rst_leds", 32'(leds), 32'hFF);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd1);

        // Heartbeat: leds step at the 4th and 8th edge after reset release
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("hb_edge3", 32'(leds), 32'hFF);
        tick();
        checkOutput("hb_edge4", 32'(leds), 32'h00);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("hb_edge7", 32'(leds), 32'h00);
        tick();
        checkOutput("hb_edge8", 32'(leds), 32'h01);
        checkOutput("idle_state", 32'(state), 32'd0);

        // Prefill gating
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("en_state", 32'(state), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
            tick();
        end
        checkOutput("pre3_state", 32'(state), 32'd1);
        checkOutput("pre3_m_empty", 32'(m_empty), 32'd1);
        checkOutput("pre3_level", 32'(level), 32'd3);
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("pre4_state", 32'(state), 32'd2);
        checkOutput("pre4_m_empty", 32'(m_empty), 32'd0);
        checkOutput("pre4_level", 32'(level), 32'd4);

        // Drain to underrun and re-prime
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            tick();
            checkOutput("drain_m_data", 32'(m_data), 32'(i));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("drain_empty", 32'(empty), 32'd1);
        tick();
        checkOutput("udr_cnt", 32'(underrun_cnt), 32'd1);
        checkOutput("udr_state", 32'(state), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("udr_hold_cnt", 32'(underrun_cnt), 32'd1);
        checkOutput("udr_hold_state", 32'(state), 32'd1);

        // Backpressure with enable low
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("bp_state", 32'(state), 32'd0);
        checkOutput("bp_full", 32'(full), 32'd1);
        checkOutput("bp_s_ready", 32'(s_ready), 32'd0);
        checkOutput("bp_level", 32'(level), 32'd16);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("bp_ovf", 32'(overflow_cnt), 32'd3);
        checkOutput("bp_level_hold", 32'(level), 32'd16);

        // Enable with a full FIFO: IDLE -> PREFILL -> STREAM
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("full_stream_state", 32'(state), 32'd2);

        // Full FIFO with simultaneous read: only the read happens
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
        checkOutput("fullrd_s_ready", 32'(s_ready), 32'd0);
        tick();
        checkOutput("fullrd_level", 32'(level), 32'd15);
        checkOutput("fullrd_m_data", 32'(m_data), 32'h10);
        checkOutput("fullrd_full", 32'(full), 32'd0);
        checkOutput("fullrd_ovf", 32'(overflow_cnt), 32'd4);

        // Read down to level 8
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("rd7_m_data", 32'(m_data), 32'h17);
        checkOutput("rd7_level", 32'(level), 32'd8);

        // Simultaneous read/write at level 8 for 10 cycles
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'h30 + 8'(i), 1'b1, 1'b1, 1'b0);
            tick();
            checkOutput("rw_level", 32'(level), 32'd8);
            checkOutput("rw_m_data", 32'(m_data), (i < 8) ? 32'(8'h18 + 8'(i)) : 32'(8'h30 + 8'(i - 8)));
        end
        applyStimulus(1'b1, 8'h3A, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("lvl9_level", 32'(level), 32'd9);
        checkOutput("lvl9_state", 32'(state), 32'd2);

        // Flush with concurrent write and read
        applyStimulus(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_s_ready", 32'(s_ready), 32'd0);
        tick();
        checkOutput("flush_level", 32'(level), 32'd0);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_full", 32'(full), 32'd0);
        checkOutput("flush_m_data", 32'(m_data), 32'h00);
        checkOutput("flush_state", 32'(state), 32'd1);
        checkOutput("flush_ovf", 32'(overflow_cnt), 32'd4);
        checkOutput("flush_udr", 32'(underrun_cnt), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("postflush_level", 32'(level), 32'd0);
        checkOutput("postflush_state", 32'(state), 32'd1);

        // Reset mid-run
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_leds", 32'(leds), 32'hFF);
        checkOutput("midrst_state", 32'(state), 32'd0);
        checkOutput("midrst_level", 32'(level), 32'd0);
        checkOutput("midrst_ovf", 32'(overflow_cnt), 32'd0);
        checkOutput("midrst_udr", 32'(underrun_cnt), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_buffer_ctrl.md
Name: stream_buffer_ctrl

Overview:
- Parametrised sample-stream buffer between the FT245 simple-interface RX port and the modulator's FIFO-pull port.
- Replaces the bare fifo + glue in the top level.
- Adds prefill gating, so the modulator only starts after START_LEVEL samples are buffered.
- Also adds underrun recovery, overflow/underrun statistics, flush, live fill level and a parametrised heartbeat LED counter.

Parameters:
- DATA_WIDTH, 8: sample width in bits.
- DEPTH_WIDTH, 10: log2 of FIFO depth; depth = 2**DEPTH_WIDTH.
- START_LEVEL, 512: fill level required before streaming; legal range 1..2**DEPTH_WIDTH.
- REPRIME, 1: 1 = return to PREFILL after an underrun; 0 = stay in STREAM.
- CNT_WIDTH, 16: width of the statistics counters.
- HB_DIV, 126000000: clocks per heartbeat LED increment.

Ports:
- clk  in  1  system clock (128 MHz).
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  stream enable.
- flush  in  1  synchronous FIFO clear pulse.
- s_data  in  DATA_WIDTH  write data from FT245 wrapper.
- s_valid  in  1  write data valid.
- s_ready  out  1  buffer can accept data.
- m_data  out  DATA_WIDTH  sample to modulator.
- m_read  in  1  modulator read strobe.
- m_empty  out  1  gated empty presented to modulator.
- level  out  DEPTH_WIDTH+1  current occupancy.
- full  out  1  raw FIFO full.
- empty  out  1  raw FIFO empty.
- state  out  2  0 IDLE, 1 PREFILL, 2 STREAM.
- overflow_cnt  out  CNT_WIDTH  cycles with s_valid while full; saturating.
- underrun_cnt  out  CNT_WIDTH  underrun events; saturating.
- leds  out  8  heartbeat counter.

Behaviour:
- Reset values:
  - m_data 0, level 0, empty 1, full 0, m_empty 1.
  - state IDLE, both counters 0, leds 8'hFF, heartbeat prescaler 0.
  - s_ready = !full & !flush (combinational), so it is 1 right after reset.
- Write:
  - Accepted on an edge where s_valid & s_ready.
  - s_valid & full increments overflow_cnt. No data is lost; the producer holds.
- Read:
  - Accepted on an edge where m_read & !m_empty.
  - m_data is registered: it shows the popped word from the following cycle.
  - m_read while m_empty=1 is ignored; no pointer change.
- Simultaneous write and read with FIFO non-empty and non-full: both occur, level unchanged.
- Empty FIFO with a simultaneous write: only the write occurs.
- Full FIFO with a simultaneous read: only the read occurs; s_ready stays low that cycle.
- Pointers are DEPTH_WIDTH+1 bits and wrap naturally. full/empty come from MSB comparison. level = wr_ptr - rd_ptr, modulo 2**(DEPTH_WIDTH+1).
- FSM:
  - IDLE: m_empty=1 and writes are still accepted. Goes to PREFILL when enable=1.
  - PREFILL: m_empty=1. Goes to STREAM when level >= START_LEVEL; level is evaluated after this cycle's update.
  - STREAM: m_empty = empty. When empty=1 for a cycle:
    - underrun_cnt increments once per entry into the empty condition, not per cycle;
    - with REPRIME=1 the FSM goes to PREFILL.
  - Any state goes to IDLE on the next edge when enable=0.
- flush:
  - Clears pointers, level, full and empty, and m_data to 0.
  - Has priority over a same-cycle write or read.
  - Counters are preserved.
  - Next state is PREFILL if enable=1, else IDLE.
- Counters saturate at all ones.
- Heartbeat:
  - The prescaler counts 0..HB_DIV-1.
  - At HB_DIV-1, leds increments (wrapping 8'hFF to 8'h00) and the prescaler returns to 0.
- Reset mid-stream discards all contents and returns to reset values on the next edge.

Decomposition:
- Shared package/include (module_params):
  - state encodings ST_IDLE / ST_PREFILL / ST_STREAM;
  - default DATA_WIDTH, DEPTH_WIDTH and HB_DIV.
- One sub-module: sbc_fifo_core, the dual-pointer synchronous FIFO with level, full, empty and flush.
- The FSM, statistics and heartbeat stay in stream_buffer_ctrl.

Test Plan:
- Prefill: DEPTH_WIDTH=4, START_LEVEL=4, enable=1, write 3 bytes -> state=1, m_empty=1. Fourth write -> state=2, m_empty=0, level=4.
- Underrun/reprime: REPRIME=1. In STREAM with level=4, read 4 samples -> m_data 0x01..0x04 one cycle after each read. Then empty=1 -> underrun_cnt=1, state=1. Hold empty 5 more cycles -> underrun_cnt stays 1.
- Backpressure: DEPTH_WIDTH=4, write 16 bytes with reads disabled (enable=0) -> full=1, s_ready=0, level=16. Hold s_valid 3 cycles -> overflow_cnt=3, level stays 16.
- Simultaneous read/write at level=8 in STREAM for 10 cycles -> level stays 8, output order preserved.
- Flush at level=9 with a concurrent write -> level=0, empty=1, counters unchanged, state=1 (enable=1).
- Heartbeat: HB_DIV=4 -> leds goes FF->00->01 at cycles 4 and 8 after reset; rst asserted mid-run -> leds=FF, state=0.
